vx_kmu_dispatch: RTL and testbench

VX_KMU_DISPATCH -- requirements
Module: VX_kmu_dispatch

---
 rtl/vx_kmu_dispatch_pkg.sv | 30 +++
 rtl/vx_kmu_dispatch_rr_arbiter.sv | 47 ++++
 rtl/vx_kmu_dispatch.sv | 156 +++++++++++++++
 tb/tb_vx_kmu_dispatch.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_kmu_dispatch_pkg.sv
// Shared KMU definitions: dispatcher FSM states and the dispatch request
// payload. Struct field widths follow the default dispatcher configuration.
package vx_kmu_dispatch_pkg;

    localparam int KMU_NUM_CORES = 4;
    localparam int KMU_DIMW      = 16;
    localparam int KMU_CORE_BITS = (KMU_NUM_CORES > 1) ? $clog2(KMU_NUM_CORES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } kmu_state_e;

    typedef struct packed {
        logic [KMU_DIMW-1:0] block_x;
        logic [KMU_DIMW-1:0] block_y;
    } kmu_req_data_t;

    typedef struct packed {
        logic [KMU_CORE_BITS-1:0] core_id;
        kmu_req_data_t            data;
    } kmu_dispatch_req_t;

    function automatic int core_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_kmu_dispatch_rr_arbiter.sv
// Round-robin arbiter. Picks the first requester at or after the pointer;
// when advance is high the pointer moves to the slot after the grant.
// Ports:
//   clk, reset   : clock, async active-high reset (pointer -> 0)
//   req          : per-slot eligibility
//   advance      : grant consumed this cycle
//   grant_valid  : at least one requester
//   grant_idx    : chosen slot
module vx_kmu_dispatch_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx
);

    logic [W-1:0] ptr_q;
    int           idx;

    // Scanning from the far end back toward ptr_q leaves the nearest match as the winner.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) idx = idx - N;
            if (req[idx[W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = idx[W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (advance && grant_valid) begin
            ptr_q <= (grant_idx == W'(N - 1)) ? '0 : grant_idx + W'(1);
        end
    end

endmodule

// File: rtl/vx_kmu_dispatch.sv
// Kernel block dispatcher: walks a grid_x * grid_y block grid in row-major
// order and hands each block to a core with spare credit, round-robin.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_IDLE  | waiting for a kernel launch (start_ready=1)
//   ST_ISSUE | loading blocks into the one-entry request register
//   ST_DRAIN | all blocks dispatched, waiting for credits to return
//   ST_DONE  | one-cycle done pulse
//
// Ports:
//   clk, reset               : clock, async active-high reset
//   start_valid/start_ready  : launch handshake, grid_x/grid_y sampled on it
//   req_valid/req_ready      : block dispatch handshake
//   req_core_id, req_block_* : dispatched block and its target core
//   cmpl_valid               : per-core block completion pulses
//   busy, done               : kernel active, end-of-kernel pulse
module vx_kmu_dispatch
    import vx_kmu_dispatch_pkg::*;
#(
    parameter  int NUM_CORES    = 4,
    parameter  int MAX_INFLIGHT = 2,
    parameter  int DIMW         = 16,
    localparam int CORE_BITS    = core_bits(NUM_CORES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [DIMW-1:0]      grid_x,
    input  logic [DIMW-1:0]      grid_y,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic [CORE_BITS-1:0] req_core_id,
    output logic [DIMW-1:0]      req_block_x,
    output logic [DIMW-1:0]      req_block_y,
    input  logic [NUM_CORES-1:0] cmpl_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    kmu_state_e        state_q, state_d;
    logic [DIMW-1:0]   gx_q, gy_q, cnt_x_q, cnt_y_q;
    logic [DIMW-1:0]   gx_last, gy_last;
    logic              more_q;
    kmu_dispatch_req_t req_q;
    logic              req_valid_q;
    logic [CW-1:0]     credit_q [NUM_CORES];
    logic [CW-1:0]     credit_d [NUM_CORES];
    logic              credits_idle_d;
    logic [NUM_CORES-1:0] eligible;
    logic              grant_valid;
    logic [CORE_BITS-1:0] grant_idx;
    logic              start_hs, req_hs, load, last_hs;

    assign gx_last  = gx_q - DIMW'(1);
    assign gy_last  = gy_q - DIMW'(1);
    assign start_hs = start_valid && (state_q == ST_IDLE);
    assign req_hs   = req_valid_q && req_ready;
    assign load     = (state_q == ST_ISSUE) && (!req_valid_q || req_ready) && more_q && grant_valid;
    assign last_hs  = req_hs && (DIMW'(req_q.data.block_x) == gx_last)
                             && (DIMW'(req_q.data.block_y) == gy_last);

    always_comb begin
        for (int c = 0; c < NUM_CORES; c++) begin
            eligible[c] = credit_q[c] < CW'(MAX_INFLIGHT);
        end
    end

    vx_kmu_dispatch_rr_arbiter #(
        .N (NUM_CORES),
        .W (CORE_BITS)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (eligible),
        .advance     (load),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Charge at load, refund on completion; a refund against an empty counter is dropped.
    always_comb begin
        credits_idle_d = 1'b1;
        for (int c = 0; c < NUM_CORES; c++) begin
            credit_d[c] = credit_q[c];
            if (load && (grant_idx == CORE_BITS'(c))) credit_d[c] = credit_d[c] + CW'(1);
            if (cmpl_valid[c] && (credit_q[c] != '0)) credit_d[c] = credit_d[c] - CW'(1);
            if (credit_d[c] != '0) credits_idle_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_valid) state_d = ((grid_x == '0) || (grid_y == '0)) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (last_hs) state_d = ST_DRAIN;
            ST_DRAIN: if (credits_idle_d) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gx_q        <= '0;
            gy_q        <= '0;
            cnt_x_q     <= '0;
            cnt_y_q     <= '0;
            more_q      <= 1'b0;
            req_valid_q <= 1'b0;
            req_q       <= '0;
            for (int c = 0; c < NUM_CORES; c++) credit_q[c] <= '0;
        end else begin
            state_q <= state_d;
            for (int c = 0; c < NUM_CORES; c++) credit_q[c] <= credit_d[c];

            if (start_hs) begin
                gx_q    <= grid_x;
                gy_q    <= grid_y;
                cnt_x_q <= '0;
                cnt_y_q <= '0;
                more_q  <= 1'b1;
            end else if (load) begin
                if (cnt_x_q == gx_last) begin
                    cnt_x_q <= '0;
                    if (cnt_y_q == gy_last) more_q <= 1'b0;
                    else cnt_y_q <= cnt_y_q + DIMW'(1);
                end else begin
                    cnt_x_q <= cnt_x_q + DIMW'(1);
                end
            end

            if (load) begin
                req_valid_q        <= 1'b1;
                req_q.core_id      <= KMU_CORE_BITS'(grant_idx);
                req_q.data.block_x <= KMU_DIMW'(cnt_x_q);
                req_q.data.block_y <= KMU_DIMW'(cnt_y_q);
            end else if (req_hs) begin
                req_valid_q <= 1'b0;
            end
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign req_valid   = req_valid_q;
    assign req_core_id = CORE_BITS'(req_q.core_id);
    assign req_block_x = DIMW'(req_q.data.block_x);
    assign req_block_y = DIMW'(req_q.data.block_y);

endmodule

// File: tb/tb_vx_kmu_dispatch.sv
module tb_vx_kmu_dispatch;

    localparam int NC = 4;
    localparam int MI = 2;
    localparam int DW = 16;
    localparam int CB = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_valid;
    logic          start_ready;
    logic [DW-1:0] grid_x, grid_y;
    logic          req_valid;
    logic          req_ready;
    logic [CB-1:0] req_core_id;
    logic [DW-1:0] req_block_x, req_block_y;
    logic [NC-1:0] cmpl_valid;
    logic          busy, done;

    always #5 clk = ~clk;

    vx_kmu_dispatch #(.NUM_CORES(NC), .MAX_INFLIGHT(MI), .DIMW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .grid_x      (grid_x),
        .grid_y      (grid_y),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_core_id (req_core_id),
        .req_block_x (req_block_x),
        .req_block_y (req_block_y),
        .cmpl_valid  (cmpl_valid),
        .busy        (busy),
        .done        (done)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // Blocks are numbered linearly n = y*grid_x + x; phase 0 idle, 1 issuing, 2 draining, 3 done.
    int m_phase, m_gx, m_gy, m_n, m_ptr, m_core, m_bx, m_by;
    int m_cred [NC];
    bit m_vld;

    function automatic void model_step();
        bit hs_req = m_vld && req_ready;
        int total  = m_gx * m_gy;
        int pick   = -1;
        bit load;
        bit allz   = 1'b1;
        for (int i = 0; i < NC; i++) begin
            if (pick < 0 && m_cred[(m_ptr + i) % NC] < MI) pick = (m_ptr + i) % NC;
        end
        load = (m_phase == 1) && (!m_vld || req_ready) && (m_n < total) && (pick >= 0);
        for (int c = 0; c < NC; c++) begin
            m_cred[c] = m_cred[c] + ((load && pick == c) ? 1 : 0) - ((cmpl_valid[c] && m_cred[c] > 0) ? 1 : 0);
            if (m_cred[c] != 0) allz = 1'b0;
        end
        case (m_phase)
            0: if (start_valid) begin
                   m_gx = int'(grid_x);
                   m_gy = int'(grid_y);
                   m_n = 0;
                   m_phase = (m_gx == 0 || m_gy == 0) ? 3 : 1;
               end
            1: if (hs_req && m_bx == m_gx - 1 && m_by == m_gy - 1) m_phase = 2;
            2: if (allz) m_phase = 3;
            default: m_phase = 0;
        endcase
        if (load) begin
            m_vld = 1'b1;
            m_core = pick;
            m_bx = m_n % m_gx;
            m_by = m_n / m_gx;
            m_n++;
            m_ptr = (pick + 1) % NC;
        end else if (hs_req) begin
            m_vld = 1'b0;
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_gx = 0; m_gy = 0; m_n = 0; m_ptr = 0;
            m_core = 0; m_bx = 0; m_by = 0; m_vld = 1'b0;
            for (int c = 0; c < NC; c++) m_cred[c] = 0;
        end else begin
            model_step();
        end
    end

    // ---------------- per-cycle compare and monitor ----------------
    bit chk_en = 1'b0;
    int hs_core[$], hs_x[$], hs_y[$];
    int done_cnt = 0;
    int vld_cnt = 0;
    bit last_hs = 1'b0;
    int last_core = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("start_ready", start_ready, m_phase == 0);
            check("busy", busy, m_phase != 0);
            check("done", done, m_phase == 3);
            check("req_valid", req_valid, m_vld);
            if (m_vld) begin
                check("req_core_id", req_core_id, m_core);
                check("req_block_x", req_block_x, m_bx);
                check("req_block_y", req_block_y, m_by);
            end
            for (int c = 0; c < NC; c++) check($sformatf("credit%0d", c), dut.credit_q[c], m_cred[c]);
        end
    end

    always @(negedge clk) begin
        last_hs = req_valid && req_ready;
        last_core = int'(req_core_id);
        if (req_valid && req_ready) begin
            hs_core.push_back(int'(req_core_id));
            hs_x.push_back(int'(req_block_x));
            hs_y.push_back(int'(req_block_y));
        end
        if (done) done_cnt++;
        if (req_valid) vld_cnt++;
    end

    // ---------------- stimulus ----------------
    int  cmpl_mode = 0;   // 0 none/manual one-shot, 1 echo last handshake, 2 random
    bit  rdy_rand = 1'b0;
    bit  start_rand = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
        case (cmpl_mode)
            1: cmpl_valid = last_hs ? (NC'(1) << last_core) : '0;
            2: for (int c = 0; c < NC; c++) cmpl_valid[c] = ($urandom_range(0, 2) == 0);
            default: cmpl_valid = '0;
        endcase
        if (rdy_rand) req_ready = ($urandom_range(0, 3) != 0);
        if (start_rand) begin
            start_valid = ($urandom_range(0, 3) == 0);
            grid_x = DW'($urandom_range(0, 4));
            grid_y = DW'($urandom_range(0, 4));
        end
    endtask

    task automatic wait_done(input int limit, input string name);
        int n = 0;
        while (n < limit && !done) begin
            step();
            n++;
        end
        check(name, done, 1);
    endtask

    task automatic launch(input int gx, input int gy);
        grid_x = DW'(gx);
        grid_y = DW'(gy);
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
    endtask

    int exp_core[6] = '{0, 1, 2, 3, 0, 1};
    int exp_x[6]    = '{0, 1, 2, 0, 1, 2};
    int exp_y[6]    = '{0, 0, 0, 1, 1, 1};
    int base, dbase, vbase, n;

    initial begin
        start_valid = 1'b0; grid_x = '0; grid_y = '0; req_ready = 1'b0; cmpl_valid = '0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        check("rst_start_ready", start_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_req_valid", req_valid, 0);
        check("rst_req_fields", {req_core_id, req_block_x, req_block_y}, 0);

        // 3x2 grid, always ready, completions echo each handshake
        cmpl_mode = 1; req_ready = 1'b1;
        base = hs_core.size(); dbase = done_cnt;
        launch(3, 2);
        wait_done(100, "g3x2_done_timeout");
        step();
        check("g3x2_count", hs_core.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < hs_core.size()) begin
                check($sformatf("g3x2_core%0d", i), hs_core[base + i], exp_core[i]);
                check($sformatf("g3x2_x%0d", i), hs_x[base + i], exp_x[i]);
                check($sformatf("g3x2_y%0d", i), hs_y[base + i], exp_y[i]);
            end
        end
        check("g3x2_done_pulses", done_cnt - dbase, 1);

        // 0x5 grid: done during the cycle after the handshake edge, i.e. sampled
        // high at the second rising edge counting the handshake edge
        cmpl_mode = 0;
        base = hs_core.size(); dbase = done_cnt; vbase = vld_cnt;
        launch(0, 5);
        check("g0x5_done_at_2", done, 1);
        check("g0x5_busy", busy, 1);
        step();
        check("g0x5_done_len", done, 0);
        check("g0x5_idle", start_ready, 1);
        step();
        check("g0x5_no_req", hs_core.size() - base, 0);
        check("g0x5_no_valid", vld_cnt - vbase, 0);
        check("g0x5_done_pulses", done_cnt - dbase, 1);

        // 10x1 grid, no completions: credit limit stalls after 8
        base = hs_core.size();
        launch(10, 1);
        repeat (20) step();
        check("g10_stall_count", hs_core.size() - base, 8);
        check("g10_stall_valid", req_valid, 0);
        for (int c = 0; c < NC; c++) check($sformatf("g10_credit%0d", c), dut.credit_q[c], 2);
        cmpl_valid = 4'b0100;
        repeat (10) step();
        check("g10_one_more", hs_core.size() - base, 9);
        if (hs_core.size() > 0) check("g10_core2", hs_core[hs_core.size() - 1], 2);
        cmpl_mode = 2;
        wait_done(500, "g10_done_timeout");
        step();

        // back-pressure hold and credit corner cases, pointer fresh from reset
        cmpl_mode = 0; req_ready = 1'b0;
        reset = 1'b1; step(); step(); reset = 1'b0;
        launch(4, 4);
        step();
        for (int i = 0; i < 6; i++) begin
            check("hold_valid", req_valid, 1);
            check("hold_fields", {req_core_id, req_block_x, req_block_y}, 0);
            check("hold_credit0", dut.credit_q[0], 1);
            step();
        end
        req_ready = 1'b1;
        cmpl_valid = 4'b1000;
        step();
        check("c3_zero_ignored", dut.credit_q[3], 0);
        check("c1_loaded", dut.credit_q[1], 1);
        check("c1_core", req_core_id, 1);
        step(); step(); step();
        check("c0_second", dut.credit_q[0], 2);
        check("c0_core", req_core_id, 0);
        cmpl_valid = 4'b0010;
        step();
        check("c1_load_and_cmpl", dut.credit_q[1], 1);
        check("c1_core_again", req_core_id, 1);

        // reset mid-kernel after three requests, then a clean 1x1 kernel
        reset = 1'b1; step(); reset = 1'b0;
        base = hs_core.size();
        launch(4, 4);
        n = 0;
        while (hs_core.size() - base < 3 && n < 20) begin
            step();
            n++;
        end
        check("rst3_reached", hs_core.size() - base, 3);
        dbase = done_cnt;
        reset = 1'b1;
        #1;
        check("rst3_valid", req_valid, 0);
        check("rst3_busy", busy, 0);
        check("rst3_fields", {req_core_id, req_block_x, req_block_y}, 0);
        for (int c = 0; c < NC; c++) check($sformatf("rst3_credit%0d", c), dut.credit_q[c], 0);
        step();
        reset = 1'b0;
        repeat (3) step();
        check("rst3_no_done", done_cnt - dbase, 0);
        check("rst3_ready", start_ready, 1);
        cmpl_mode = 1;
        base = hs_core.size();
        launch(1, 1);
        wait_done(50, "g1x1_done_timeout");
        step();
        check("g1x1_count", hs_core.size() - base, 1);
        if (hs_core.size() > base) begin
            check("g1x1_core", hs_core[base], 0);
            check("g1x1_block", {hs_x[base][15:0], hs_y[base][15:0]}, 0);
        end
        check("g1x1_done", done_cnt - dbase, 1);

        // randomized traffic: random grids, starts at any time, random ready and completions
        cmpl_mode = 2; rdy_rand = 1'b1; start_rand = 1'b1;
        dbase = done_cnt;
        repeat (3000) step();
        start_rand = 1'b0; start_valid = 1'b0;
        repeat (200) step();
        check("rand_kernels_finished", (done_cnt - dbase) > 10, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
